// File: rtl/level_sequencer.sv
// Level sequencer: owns the current level index and its base address in the
// shared level memory. Level-complete / death events are latched and acted on
// at the next frame boundary. Each level (re)load streams the tile-word
// addresses to the memory arbiter over a req/ack handshake.
//
// Handshake: load_req is high for the whole LOAD state and load_addr is stable
// while load_req=1 && load_ack=0. A word counts as transferred on a clock edge
// where load_req=1 && load_ack=1. load_ack while load_req=0 is ignored.
module level_sequencer #(
    parameter int LEVEL_WORDS = 75,
    parameter int NUM_LEVELS  = 8,
    parameter int ADDR_W      = 11
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              new_level,
    input  logic              death,
    input  logic              frame_start,
    input  logic              load_ack,
    output logic              load_req,
    output logic [ADDR_W-1:0] load_addr,
    output logic              load_done,
    output logic [ADDR_W-1:0] level_base,
    output logic [6:0]        level_num,
    output logic [7:0]        level_bcd,
    output logic              game_won,
    output logic [2:0]        state_dbg
);

    localparam int IDX_W = $clog2(LEVEL_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEVEL_WORDS - 1);

    typedef enum logic [2:0] {
        INIT = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        PEND = 3'd3,
        WON  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        level_num_q, level_num_d;
    logic [ADDR_W-1:0] level_base_q, level_base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pend_adv_q, pend_adv_d;
    logic              pend_rst_q, pend_rst_d;
    logic              new_level_prev_q, new_level_prev_d;
    logic              death_prev_q, death_prev_d;
    logic              load_done_q, load_done_d;
    logic              game_won_q, game_won_d;

    logic adv_edge;
    logic rst_edge;

    // Edge detection: the previous-value registers always track the inputs,
    // so a request held high across a transition never re-triggers.
    assign adv_edge         = new_level & ~new_level_prev_q;
    assign rst_edge         = death & ~death_prev_q;
    assign new_level_prev_d = new_level;
    assign death_prev_d     = death;

    // Next-state and register-update logic for the sequencer FSM
    always_comb begin
        state_d      = state_q;
        level_num_d  = level_num_q;
        level_base_d = level_base_q;
        idx_d        = idx_q;
        pend_adv_d   = pend_adv_q;
        pend_rst_d   = pend_rst_q;
        load_done_d  = 1'b0;
        game_won_d   = game_won_q;
        case (state_q)
            INIT: begin
                idx_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                if (load_ack) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d       = '0;
                        load_done_d = 1'b1;
                        state_d     = PLAY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                // Advance wins over a simultaneous death edge.
                if (adv_edge) begin
                    pend_adv_d = 1'b1;
                    pend_rst_d = 1'b0;
                    state_d    = PEND;
                end else if (rst_edge) begin
                    pend_rst_d = 1'b1;
                    state_d    = PEND;
                end
            end
            PEND: begin
                // Merge later edges; a pending advance absorbs any death.
                if (adv_edge) begin
                    pend_adv_d = 1'b1;
                    pend_rst_d = 1'b0;
                end else if (rst_edge && !pend_adv_q) begin
                    pend_rst_d = 1'b1;
                end
                if (frame_start) begin
                    if (pend_adv_d) begin
                        if (level_num_q == 7'(NUM_LEVELS)) begin
                            game_won_d = 1'b1;
                            state_d    = WON;
                        end else begin
                            level_num_d  = level_num_q + 7'd1;
                            level_base_d = level_base_q + ADDR_W'(LEVEL_WORDS);
                            idx_d        = '0;
                            state_d      = LOAD;
                        end
                    end else begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end
                    pend_adv_d = 1'b0;
                    pend_rst_d = 1'b0;
                end
            end
            WON: begin
                game_won_d = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_q          <= INIT;
            level_num_q      <= 7'd1;
            level_base_q     <= '0;
            idx_q            <= '0;
            pend_adv_q       <= 1'b0;
            pend_rst_q       <= 1'b0;
            new_level_prev_q <= 1'b0;
            death_prev_q     <= 1'b0;
            load_done_q      <= 1'b0;
            game_won_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            level_num_q      <= level_num_d;
            level_base_q     <= level_base_d;
            idx_q            <= idx_d;
            pend_adv_q       <= pend_adv_d;
            pend_rst_q       <= pend_rst_d;
            new_level_prev_q <= new_level_prev_d;
            death_prev_q     <= death_prev_d;
            load_done_q      <= load_done_d;
            game_won_q       <= game_won_d;
        end
    end

    // Binary-to-BCD of level_num by repeated subtraction of ten (1..99)
    logic [6:0] ones_v;
    logic [3:0] tens_v;
    always_comb begin
        ones_v = level_num_q;
        tens_v = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (ones_v >= 7'd10) begin
                ones_v = ones_v - 7'd10;
                tens_v = tens_v + 4'd1;
            end
        end
        level_bcd = {tens_v, ones_v[3:0]};
    end

    assign load_req   = (state_q == LOAD);
    assign load_addr  = level_base_q + ADDR_W'(idx_q);
    assign load_done  = load_done_q;
    assign level_base = level_base_q;
    assign level_num  = level_num_q;
    assign game_won   = game_won_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: boot load, advance, merge rules,
// ack stalls, win, reset mid-load, plus a small-level instance for 2-digit BCD.
module tb_level_sequencer;

    localparam int ST_INIT = 0;
    localparam int ST_LOAD = 1;
    localparam int ST_PLAY = 2;
    localparam int ST_PEND = 3;
    localparam int ST_WON  = 4;

    // Clock
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Main instance (default parameters)
    logic        RESET, new_level, death, frame_start, load_ack;
    logic        load_req, load_done, game_won;
    logic [10:0] load_addr, level_base;
    logic [6:0]  level_num;
    logic [7:0]  level_bcd;
    logic [2:0]  state_dbg;

    level_sequencer dut (
        .Clk(Clk), .RESET(RESET), .new_level(new_level), .death(death),
        .frame_start(frame_start), .load_ack(load_ack), .load_req(load_req),
        .load_addr(load_addr), .load_done(load_done), .level_base(level_base),
        .level_num(level_num), .level_bcd(level_bcd), .game_won(game_won),
        .state_dbg(state_dbg)
    );

    // Second instance: short levels, 12 of them, to reach two-digit BCD
    logic        b_reset, b_new, b_death, b_fs, b_ack;
    logic        b_req, b_done, b_won;
    logic [10:0] b_addr, b_base;
    logic [6:0]  b_num;
    logic [7:0]  b_bcd;
    logic [2:0]  b_state;

    level_sequencer #(.LEVEL_WORDS(2), .NUM_LEVELS(12), .ADDR_W(11)) dut_b (
        .Clk(Clk), .RESET(b_reset), .new_level(b_new), .death(b_death),
        .frame_start(b_fs), .load_ack(b_ack), .load_req(b_req),
        .load_addr(b_addr), .load_done(b_done), .level_base(b_base),
        .level_num(b_num), .level_bcd(b_bcd), .game_won(b_won),
        .state_dbg(b_state)
    );

    int n_cmp    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
        if (load_done === 1'b1) done_cnt++;
    endtask

    // Expects LOAD showing base+0; streams all 75 words, optional 3-cycle stall.
    task automatic run_load(input int base, input int stall_idx);
        int d0;
        d0 = done_cnt;
        load_ack = 1'b1;
        for (int i = 0; i < 75; i++) begin
            if (i == stall_idx) begin
                load_ack = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check("stall_addr", load_addr, base + i);
                    check("stall_req", load_req, 1);
                    step();
                end
                load_ack = 1'b1;
            end
            check("load_addr", load_addr, base + i);
            check("load_req", load_req, 1);
            check("load_done_low", load_done, 0);
            step();
        end
        check("load_done_pulse", load_done, 1);
        check("play_after_load", state_dbg, ST_PLAY);
        check("req_off_after_load", load_req, 0);
        check("done_cnt_one", done_cnt, d0 + 1);
        step();
        check("load_done_clear", load_done, 0);
    endtask

    // Raise new_level, then frame_start on the following cycle.
    task automatic advance();
        new_level = 1'b1;
        step();
        new_level   = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        int d;
        RESET = 1'b1; new_level = 1'b0; death = 1'b0; frame_start = 1'b0; load_ack = 1'b0;
        b_reset = 1'b1; b_new = 1'b0; b_death = 1'b0; b_fs = 1'b0; b_ack = 1'b1;

        // Reset state
        step(); step();
        check("rst_state", state_dbg, ST_INIT);
        check("rst_num", level_num, 1);
        check("rst_base", level_base, 0);
        check("rst_req", load_req, 0);
        check("rst_done", load_done, 0);
        check("rst_won", game_won, 0);
        check("rst_bcd", level_bcd, 8'h01);

        // Boot load of level 1
        RESET = 1'b0; load_ack = 1'b1;
        step();
        check("boot_load", state_dbg, ST_LOAD);
        run_load(0, -1);
        check("l1_num", level_num, 1);
        check("l1_bcd", level_bcd, 8'h01);

        // frame_start in PLAY does nothing
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("fs_play_state", state_dbg, ST_PLAY);
        check("fs_play_num", level_num, 1);

        // new_level held 10 cycles, frame_start 20 cycles later
        new_level = 1'b1;
        step();
        check("pend_entry", state_dbg, ST_PEND);
        repeat (9) step();
        new_level = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check("wait_num", level_num, 1);
            check("wait_req", load_req, 0);
            step();
        end
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("l2_state", state_dbg, ST_LOAD);
        check("l2_num", level_num, 2);
        check("l2_base", level_base, 75);
        check("l2_bcd", level_bcd, 8'h02);
        run_load(75, 10);
        repeat (5) step();
        check("single_adv_state", state_dbg, ST_PLAY);
        check("single_adv_num", level_num, 2);

        // Simultaneous edges: advance wins; inputs held high do not retrigger
        new_level = 1'b1; death = 1'b1;
        step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("both_num", level_num, 3);
        check("both_base", level_base, 150);
        run_load(150, -1);
        repeat (3) step();
        check("held_no_retrig", state_dbg, ST_PLAY);
        check("held_num", level_num, 3);
        new_level = 1'b0; death = 1'b0;
        step();

        // Death edge in PEND after new_level is still an advance
        new_level = 1'b1; step(); new_level = 1'b0;
        death = 1'b1; step(); death = 1'b0;
        check("merge_pend", state_dbg, ST_PEND);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("merge_num", level_num, 4);
        check("merge_base", level_base, 225);
        run_load(225, -1);

        // Death alone reloads the same level
        death = 1'b1; step(); death = 1'b0;
        check("death_pend", state_dbg, ST_PEND);
        step(); step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("reload_state", state_dbg, ST_LOAD);
        check("reload_num", level_num, 4);
        check("reload_base", level_base, 225);
        run_load(225, -1);

        // Levels 5..8
        for (int lvl = 5; lvl <= 8; lvl++) begin
            advance();
            check("adv_num", level_num, lvl);
            check("adv_base", level_base, (lvl - 1) * 75);
            run_load((lvl - 1) * 75, -1);
        end
        check("l8_bcd", level_bcd, 8'h08);

        // Completing level 8 wins
        d = done_cnt;
        advance();
        check("won_state", state_dbg, ST_WON);
        check("won_flag", game_won, 1);
        check("won_req", load_req, 0);
        new_level = 1'b1; death = 1'b1; frame_start = 1'b1;
        step();
        new_level = 1'b0; death = 1'b0; frame_start = 1'b0;
        step();
        death = 1'b1; step(); death = 1'b0;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("won_hold_state", state_dbg, ST_WON);
        check("won_hold_flag", game_won, 1);
        check("won_hold_num", level_num, 8);
        check("won_hold_req", load_req, 0);
        check("won_no_done", done_cnt, d);

        // Reset out of WON, reboot, then reset in the middle of level 3's load
        RESET = 1'b1; step(); RESET = 1'b0;
        check("rst2_state", state_dbg, ST_INIT);
        check("rst2_won", game_won, 0);
        step();
        run_load(0, -1);
        advance();
        run_load(75, -1);
        advance();
        check("l3_base", level_base, 150);
        for (int i = 0; i < 40; i++) step();
        check("idx40_addr", load_addr, 190);
        d = done_cnt;
        RESET = 1'b1; step();
        check("abort_state", state_dbg, ST_INIT);
        check("abort_num", level_num, 1);
        check("abort_base", level_base, 0);
        check("abort_req", load_req, 0);
        check("abort_done", load_done, 0);
        RESET = 1'b0; step();
        check("abort_no_done", done_cnt, d);
        check("reboot_state", state_dbg, ST_LOAD);
        run_load(0, -1);

        // Two-digit BCD on the short-level instance
        b_reset = 1'b0;
        for (int lvl = 1; lvl <= 12; lvl++) begin
            for (int k = 0; k < 10 && b_state != 3'(ST_PLAY); k++) step();
            check("b_play", b_state, ST_PLAY);
            check("b_num", b_num, lvl);
            check("b_bcd", b_bcd, ((lvl / 10) << 4) | (lvl % 10));
            check("b_base", b_base, (lvl - 1) * 2);
            b_new = 1'b1; step(); b_new = 1'b0;
            b_fs = 1'b1; step(); b_fs = 1'b0;
            if (lvl < 12) begin
                check("b_load", b_state, ST_LOAD);
                check("b_addr", b_addr, lvl * 2);
            end
        end
        check("b_won_state", b_state, ST_WON);
        check("b_won_flag", b_won, 1);
        check("b_won_req", b_req, 0);
        check("b_won_done", b_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
